// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/flopenrc.sv
// Enabled register with synchronous reset and synchronous clear.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and load/store, one
// outstanding transaction at a time, alternating grants under contention.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_data_ok,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_sel,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_data_ok,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stallreq_if,
    output logic                stallreq_mem
);

    localparam int SEL_W = DATA_W / 8;
    localparam int REQ_W = 1 + SEL_W + ADDR_W + DATA_W;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_owner_q, last_owner_d;
    logic             grant;
    logic             grant_data;
    logic             complete;
    logic [REQ_W-1:0] req_d, req_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant        = 1'b0;
        grant_data   = 1'b0;
        complete     = 1'b0;
        bus_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Data wins a tie unless it owned the previous transaction.
                if (data_req || inst_req) begin
                    grant      = 1'b1;
                    grant_data = data_req && !(inst_req && (last_owner_q == OWN_DATA));
                    owner_d    = grant_data ? OWN_DATA : OWN_INST;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        complete = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    complete = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
        end

        if (rst) begin
            state_d      = ST_IDLE;
            owner_d      = OWN_INST;
            last_owner_d = OWN_INST;
            grant        = 1'b0;
            complete     = 1'b0;
            bus_req      = 1'b0;
        end

        req_d = grant_data ? {data_wr, data_sel, data_addr, data_wdata}
                           : {1'b0, {SEL_W{1'b0}}, inst_addr, {DATA_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    flopenrc #(
        .WIDTH(REQ_W)
    ) u_req_reg (
        .clk  (clk),
        .rst  (rst),
        .en   (grant),
        .clear(1'b0),
        .d    (req_d),
        .q    (req_q)
    );

    assign {bus_wr, bus_sel, bus_addr, bus_wdata} = req_q;

    assign inst_data_ok = complete && (owner_q == OWN_INST);
    assign data_data_ok = complete && (owner_q == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

    assign stallreq_if  = inst_req & ~inst_data_ok;
    assign stallreq_mem = data_req & ~data_data_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scripted requesters, a wait-state slave and an
// expected-completion queue checked on every data_ok pulse.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 1 + 1 + SW + AW + DW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_data_ok;
  logic          data_req;
  logic          data_wr;
  logic [SW-1:0] data_sel;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_data_ok;
  logic          bus_req;
  logic          bus_wr;
  logic [SW-1:0] bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          stallreq_if;
  logic          stallreq_mem;

  int            total = 0;
  int            bad = 0;
  logic [EW-1:0] exp_q[$];

  int            addr_wait = 0;
  int            data_wait = 0;
  logic          stray_data_ok = 1'b0;
  logic          rd_ovr_en = 1'b0;
  logic [DW-1:0] rd_ovr = '0;
  logic          sl_phase;
  int            sl_cnt;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_data_ok(inst_data_ok),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_sel    (data_sel),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_data_ok(data_data_ok),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .stallreq_if (stallreq_if),
    .stallreq_mem(stallreq_mem)
  );

  function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Slave: addr_ok after addr_wait cycles of bus_req, data_ok data_wait cycles later.
  always_comb begin
    bus_addr_ok = bus_req && !sl_phase && (sl_cnt == addr_wait);
    bus_data_ok = stray_data_ok || (bus_addr_ok && (data_wait == 0)) ||
                  (sl_phase && (sl_cnt == data_wait));
    bus_rdata   = bus_data_ok ? (rd_ovr_en ? rd_ovr : slave_rd(bus_addr)) : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      sl_phase <= 1'b0;
      sl_cnt   <= 0;
    end else if (!sl_phase) begin
      if (bus_req) begin
        if (bus_addr_ok) begin
          if (data_wait == 0) begin
            sl_cnt <= 0;
          end else begin
            sl_phase <= 1'b1;
            sl_cnt   <= 1;
          end
        end else begin
          sl_cnt <= sl_cnt + 1;
        end
      end
    end else if (sl_cnt == data_wait) begin
      sl_phase <= 1'b0;
      sl_cnt   <= 0;
    end else begin
      sl_cnt <= sl_cnt + 1;
    end
  end

  task automatic do_reset();
    rst           = 1'b1;
    inst_req      = 1'b0;
    inst_addr     = '0;
    data_req      = 1'b0;
    data_wr       = 1'b0;
    data_sel      = '0;
    data_addr     = '0;
    data_wdata    = '0;
    addr_wait     = 0;
    data_wait     = 0;
    stray_data_ok = 1'b0;
    rd_ovr_en     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [150:0] got;
    rst = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h1234_5678;
    data_req = 1'b0;
    stray_data_ok = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {bus_req, bus_wr, bus_sel, bus_addr, bus_wdata, inst_data_ok,
           data_data_ok, inst_rdata, data_rdata};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    total++;
    if (stallreq_if !== 1'b1 || stallreq_mem !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b%b exp=10", stallreq_if, stallreq_mem);
    end
    do_reset();
  endtask

  task automatic test_fetch();
    logic [EW-1:0] e;
    do_reset();
    rd_ovr_en = 1'b1;
    rd_ovr    = 32'h3C08_0001;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    exp_q.push_back({1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C08_0001});
    @(negedge clk);
    total++;
    if (bus_req !== 1'b0 || inst_data_ok !== 1'b0 || stallreq_if !== 1'b1) begin
      bad++;
      $display("FAIL fetch_c0 got=%b%b%b exp=001", bus_req, inst_data_ok, stallreq_if);
    end
    @(negedge clk);
    total++;
    if ({bus_req, bus_wr, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'h0, 32'hBFC0_0000}) begin
      bad++;
      $display("FAIL fetch_bus got=%b %b %h %h", bus_req, bus_wr, bus_sel, bus_addr);
    end
    total++;
    if (inst_data_ok !== 1'b1 || stallreq_if !== 1'b0) begin
      bad++;
      $display("FAIL fetch_ok got=%b%b exp=10", inst_data_ok, stallreq_if);
    end
    if (inst_data_ok === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({1'b0, bus_wr, bus_sel, bus_addr, bus_wdata, inst_rdata} !== e) begin
        bad++;
        $display("FAIL fetch_data got=%h exp=%h", inst_rdata, e[DW-1:0]);
      end
    end
    @(posedge clk);
    #1 inst_req = 1'b0;
    rd_ovr_en = 1'b0;
    @(negedge clk);
    total++;
    if (inst_data_ok !== 1'b0 || bus_req !== 1'b0 || inst_rdata !== '0) begin
      bad++;
      $display("FAIL fetch_after got=%b%b %h exp=00 0", inst_data_ok, bus_req, inst_rdata);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL fetch_queue got=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_store_wait();
    logic [EW-1:0] e;
    int ok_cnt = 0;
    do_reset();
    addr_wait     = 2;
    data_wait     = 3;
    data_req      = 1'b1;
    data_wr       = 1'b1;
    data_sel      = 4'b0011;
    data_addr     = 32'h8000_0002;
    data_wdata    = 32'h1234_1234;
    stray_data_ok = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 4'b0011, 32'h8000_0002, 32'h1234_1234,
                     slave_rd(32'h8000_0002)});
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (bus_req !== (c >= 1 && c <= 3)) begin
        bad++;
        $display("FAIL store_bus_req c=%0d got=%b", c, bus_req);
      end
      total++;
      if (data_data_ok !== (c == 6)) begin
        bad++;
        $display("FAIL store_ok c=%0d got=%b", c, data_data_ok);
      end
      total++;
      if (stallreq_mem !== (c < 6)) begin
        bad++;
        $display("FAIL store_stall c=%0d got=%b", c, stallreq_mem);
      end
      if (c >= 1 && c <= 6) begin
        total++;
        if ({bus_wr, bus_sel, bus_addr, bus_wdata} !== {1'b1, 4'b0011, 32'h8000_0002, 32'h1234_1234}) begin
          bad++;
          $display("FAIL store_fields c=%0d got=%b %h %h %h", c, bus_wr, bus_sel, bus_addr, bus_wdata);
        end
      end
      if (data_data_ok === 1'b1) begin
        ok_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          if ({1'b1, bus_wr, bus_sel, bus_addr, bus_wdata, data_rdata} !== e) begin
            bad++;
            $display("FAIL store_data got=%h exp=%h", data_rdata, e[DW-1:0]);
          end
        end
      end else begin
        total++;
        if (data_rdata !== '0) begin
          bad++;
          $display("FAIL store_rdata_idle c=%0d got=%h exp=0", c, data_rdata);
        end
      end
      @(posedge clk);
      #1 stray_data_ok = (c + 1 <= 2);
      if (c == 6) data_req = 1'b0;
    end
    total++;
    if (ok_cnt != 1) begin
      bad++;
      $display("FAIL store_pulses got=%0d exp=1", ok_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_contention(input int n_data, input int n_inst, input bit rand_waits);
    logic [AW-1:0] da[8];
    logic [AW-1:0] ia[8];
    logic          dwr[8];
    logic [SW-1:0] dsel[8];
    logic [DW-1:0] dwd[8];
    logic [EW-1:0] e;
    logic          d_ok, i_ok, last_d;
    int            di, ii, done, cyc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      da[k]   = {$urandom_range(0, 32'hFFFF), 16'h0} | (k << 2);
      ia[k]   = 32'hBFC0_0000 + (k << 2);
      dwr[k]  = 1'($urandom_range(0, 1));
      dsel[k] = 4'($urandom_range(1, 15));
      dwd[k]  = $urandom;
    end
    last_d = 1'b0;
    di = 0;
    ii = 0;
    while (di < n_data || ii < n_inst) begin
      if (di < n_data && (ii >= n_inst || !last_d)) begin
        exp_q.push_back({1'b1, dwr[di], dsel[di], da[di], dwd[di], slave_rd(da[di])});
        last_d = 1'b1;
        di++;
      end else begin
        exp_q.push_back({1'b0, 1'b0, 4'h0, ia[ii], 32'h0, slave_rd(ia[ii])});
        last_d = 1'b0;
        ii++;
      end
    end
    di = 0;
    ii = 0;
    if (rand_waits) begin
      addr_wait = $urandom_range(0, 2);
      data_wait = $urandom_range(0, 2);
    end
    data_req   = (n_data > 0);
    data_wr    = dwr[0];
    data_sel   = dsel[0];
    data_addr  = da[0];
    data_wdata = dwd[0];
    inst_req   = (n_inst > 0);
    inst_addr  = ia[0];
    done = 0;
    cyc  = 0;
    while (done < n_data + n_inst && cyc < 200) begin
      @(negedge clk);
      cyc++;
      d_ok = data_data_ok;
      i_ok = inst_data_ok;
      total++;
      if ({stallreq_if, stallreq_mem} !== {inst_req & ~i_ok, data_req & ~d_ok}) begin
        bad++;
        $display("FAIL cont_stall cyc=%0d got=%b%b", cyc, stallreq_if, stallreq_mem);
      end
      if (d_ok || i_ok) begin
        done++;
        total++;
        if (d_ok && i_ok) begin
          bad++;
          $display("FAIL cont_both_ok cyc=%0d got=11 exp=one", cyc);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cont_extra cyc=%0d got=pulse exp=none", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({d_ok, bus_wr, bus_sel, bus_addr, bus_wdata, d_ok ? data_rdata : inst_rdata} !== e) begin
            bad++;
            $display("FAIL cont_order n=%0d got=%b %h exp=%b %h", done, d_ok, bus_addr,
                     e[EW-1], e[AW+DW+DW-1:DW+DW]);
          end
        end
      end
      @(posedge clk);
      #1;
      if (d_ok) begin
        di++;
        if (di < n_data) begin
          data_wr    = dwr[di];
          data_sel   = dsel[di];
          data_addr  = da[di];
          data_wdata = dwd[di];
        end else begin
          data_req = 1'b0;
        end
      end
      if (i_ok) begin
        ii++;
        if (ii < n_inst) inst_addr = ia[ii];
        else inst_req = 1'b0;
      end
      if ((d_ok || i_ok) && rand_waits) begin
        addr_wait = $urandom_range(0, 2);
        data_wait = $urandom_range(0, 2);
      end
    end
    total++;
    if (done != n_data + n_inst) begin
      bad++;
      $display("FAIL cont_timeout got=%0d exp=%0d", done, n_data + n_inst);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e;
    int done = 0;
    do_reset();
    addr_wait = 0;
    data_wait = 5;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_sel  = 4'hF;
    data_addr = 32'h8000_1000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_addr got=%b exp=1", bus_req);
    end
    @(negedge clk);
    total++;
    if ({bus_req, data_data_ok, stallreq_mem} !== 3'b001) begin
      bad++;
      $display("FAIL rmid_data got=%b%b%b exp=001", bus_req, data_data_ok, stallreq_mem);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_req, data_data_ok, inst_data_ok} !== 3'b000) begin
      bad++;
      $display("FAIL rmid_in_reset got=%b%b%b exp=000", bus_req, data_data_ok, inst_data_ok);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    stray_data_ok = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_req, data_data_ok, inst_data_ok, data_rdata, bus_addr} !== '0) begin
      bad++;
      $display("FAIL rmid_stray got=%b%b%b %h %h exp=000 0 0", bus_req, data_data_ok,
               inst_data_ok, data_rdata, bus_addr);
    end
    @(posedge clk);
    #1 stray_data_ok = 1'b0;
    data_wait = 0;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0040;
    data_req  = 1'b1;
    data_addr = 32'h8000_2000;
    exp_q.push_back({1'b1, 1'b0, 4'hF, 32'h8000_2000, 32'h0, slave_rd(32'h8000_2000)});
    exp_q.push_back({1'b0, 1'b0, 4'h0, 32'hBFC0_0040, 32'h0, slave_rd(32'hBFC0_0040)});
    @(negedge clk);
    total++;
    if (bus_req !== 1'b0) begin
      bad++;
      $display("FAIL rmid_grant_idle got=%b exp=0", bus_req);
    end
    for (int c = 0; c < 20 && done < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (data_data_ok || inst_data_ok) begin
        done++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          total++;
          if ({data_data_ok, bus_wr, bus_sel, bus_addr, bus_wdata, data_rdata | inst_rdata} !== e) begin
            bad++;
            $display("FAIL rmid_after got=%b %h exp=%b %h", data_data_ok, bus_addr,
                     e[EW-1], e[AW+DW+DW-1:DW+DW]);
          end
        end
        @(posedge clk);
        #1;
        if (data_data_ok) data_req = 1'b0;
        if (inst_data_ok) inst_req = 1'b0;
        if (done == 1) data_req = 1'b0;
        if (done == 2) inst_req = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    total++;
    if (done != 2) begin
      bad++;
      $display("FAIL rmid_timeout got=%0d exp=2", done);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_abandon();
    logic [EW-1:0] e;
    do_reset();
    addr_wait = 1;
    data_wait = 1;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0100;
    exp_q.push_back({1'b0, 1'b0, 4'h0, 32'hBFC0_0100, 32'h0, slave_rd(32'hBFC0_0100)});
    @(negedge clk);
    total++;
    if ({bus_req, stallreq_if} !== 2'b01) begin
      bad++;
      $display("FAIL aban_c0 got=%b%b exp=01", bus_req, stallreq_if);
    end
    @(posedge clk);
    #1 inst_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_req, stallreq_if, bus_addr} !== {2'b10, 32'hBFC0_0100}) begin
      bad++;
      $display("FAIL aban_c1 got=%b%b %h", bus_req, stallreq_if, bus_addr);
    end
    @(posedge clk);
    #1 data_req = 1'b1;
    data_wr    = 1'b0;
    data_sel   = 4'b1100;
    data_addr  = 32'h8000_0300;
    data_wdata = 32'h0;
    exp_q.push_back({1'b1, 1'b0, 4'b1100, 32'h8000_0300, 32'h0, slave_rd(32'h8000_0300)});
    @(negedge clk);
    total++;
    if ({bus_req, data_data_ok, stallreq_mem} !== 3'b101) begin
      bad++;
      $display("FAIL aban_c2 got=%b%b%b exp=101", bus_req, data_data_ok, stallreq_mem);
    end
    for (int c = 3; c <= 7; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({bus_req, inst_data_ok, data_data_ok} !== {(c == 5 || c == 6), (c == 3), (c == 7)}) begin
        bad++;
        $display("FAIL aban_c%0d got=%b%b%b", c, bus_req, inst_data_ok, data_data_ok);
      end
      if ((inst_data_ok || data_data_ok) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({data_data_ok, bus_wr, bus_sel, bus_addr, bus_wdata, data_rdata | inst_rdata} !== e) begin
          bad++;
          $display("FAIL aban_data c=%0d got=%h exp=%h", c, data_rdata | inst_rdata, e[DW-1:0]);
        end
      end
      if (c == 5) begin
        total++;
        if (bus_addr !== 32'h8000_0300) begin
          bad++;
          $display("FAIL aban_next_addr got=%h exp=80000300", bus_addr);
        end
      end
    end
    @(posedge clk);
    #1 data_req = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL aban_queue got=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_fetch();
    test_store_wait();
    test_contention(2, 2, 1'b0);
    test_contention(4, 3, 1'b1);
    test_reset_mid();
    test_abandon();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
